// File: rtl/pc_unit_if.sv
// Signal bundle between the D-stage decode/hazard logic (master) and the
// fetch-stage program-counter unit (slave).
interface pc_unit_if;
  logic        stall;
  logic        exc_req;
  logic [31:0] epc;
  logic        D_eret;
  logic [1:0]  D_branch_type;
  logic        equal;
  logic [1:0]  D_jump_type;
  logic [31:0] D_pc;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_rs_val;
  logic [31:0] F_pc;
  logic        F_bd;
  logic        F_exc_adel;
  logic        flush_F;

  modport master (
    output stall, exc_req, epc, D_eret, D_branch_type, equal, D_jump_type,
           D_pc, D_imm16, D_imm26, D_rs_val,
    input  F_pc, F_bd, F_exc_adel, flush_F
  );

  modport slave (
    input  stall, exc_req, epc, D_eret, D_branch_type, equal, D_jump_type,
           D_pc, D_imm16, D_imm26, D_rs_val,
    output F_pc, F_bd, F_exc_adel, flush_F
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage PC register and next-PC selection for the pipelined MIPS core:
// exception/eret/branch/jump redirect, delay-slot flag and fetch address error.
module pc_unit (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] WIN_LO     = 32'h0000_3000;
  localparam logic [31:0] WIN_HI     = 32'h0000_6FFC;

  logic [31:0] r_pc;
  logic        r_bd;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_d_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_pc_next;
  logic        w_bd_next;
  logic        w_br_valid;
  logic        w_br_taken;
  logic        w_jump;
  logic        w_jreg;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_d_pc_plus4 = bus.D_pc + 32'd4;
  assign w_br_offset  = {{14{bus.D_imm16[15]}}, bus.D_imm16, 2'b00};
  assign w_br_target  = w_d_pc_plus4 + w_br_offset;
  assign w_j_target   = {w_d_pc_plus4[31:28], bus.D_imm26, 2'b00};

  // Reserved encodings (11) decode as "none" for both branch and jump.
  assign w_br_valid = (bus.D_branch_type == 2'b01) || (bus.D_branch_type == 2'b10);
  assign w_br_taken = ((bus.D_branch_type == 2'b01) &&  bus.equal) ||
                      ((bus.D_branch_type == 2'b10) && !bus.equal);
  assign w_jump     = (bus.D_jump_type == 2'b01);
  assign w_jreg     = (bus.D_jump_type == 2'b10);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    w_pc_next = w_pc_plus4;
    w_bd_next = w_br_valid | w_jump | w_jreg;
    if (bus.exc_req) begin
      w_pc_next = HANDLER_PC;
      w_bd_next = 1'b0;
    end else if (bus.stall) begin
      w_pc_next = r_pc;
      w_bd_next = r_bd;
    end else if (bus.D_eret) begin
      w_pc_next = bus.epc;
      w_bd_next = 1'b0;
    end else if (w_br_valid) begin
      // A branch in D shadows any jump; not-taken falls through to F_pc + 4.
      if (w_br_taken) w_pc_next = w_br_target;
    end else if (w_jump) begin
      w_pc_next = w_j_target;
    end else if (w_jreg) begin
      w_pc_next = bus.D_rs_val;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      r_pc <= RESET_PC;
      r_bd <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      r_bd <= w_bd_next;
    end
  end

  // Bad targets are loaded as-is; the error is reported here, never redirected.
  assign bus.F_pc       = r_pc;
  assign bus.F_bd       = r_bd;
  assign bus.F_exc_adel = (r_pc[1:0] != 2'b00) || (r_pc < WIN_LO) || (r_pc > WIN_HI);
  assign bus.flush_F    = bus.D_eret & ~bus.stall & ~bus.exc_req;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: single-cycle vector table from reset,
// hand-written multi-cycle sequences, and a randomized run against a reference model.
module tb_pc_unit;
  logic clk;
  logic reset;
  pc_unit_if bus ();

  pc_unit dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        exc;
    logic        stall;
    logic        eret;
    logic [31:0] epc;
    logic [1:0]  bt;
    logic        eq;
    logic [1:0]  jt;
    logic [31:0] dpc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] pc;
    logic        bd;
    logic        flush;
    logic        adel;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic rst, input logic exc, input logic stl,
                               input logic eret, input logic [31:0] epc,
                               input logic [1:0] bt, input logic eq, input logic [1:0] jt,
                               input logic [31:0] dpc, input logic [15:0] imm16,
                               input logic [25:0] imm26, input logic [31:0] rs);
    stim_t s;
    s.rst = rst; s.exc = exc; s.stall = stl; s.eret = eret; s.epc = epc;
    s.bt = bt; s.eq = eq; s.jt = jt; s.dpc = dpc; s.imm16 = imm16;
    s.imm26 = imm26; s.rs = rs;
    return s;
  endfunction

  function automatic vec_t mv(input stim_t s, input logic [31:0] pc, input logic bd,
                              input logic flush, input logic adel);
    vec_t v;
    v.s = s; v.pc = pc; v.bd = bd; v.flush = flush; v.adel = adel;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    reset             = s.rst;
    bus.exc_req       = s.exc;
    bus.stall         = s.stall;
    bus.D_eret        = s.eret;
    bus.epc           = s.epc;
    bus.D_branch_type = s.bt;
    bus.equal         = s.eq;
    bus.D_jump_type   = s.jt;
    bus.D_pc          = s.dpc;
    bus.D_imm16       = s.imm16;
    bus.D_imm26       = s.imm26;
    bus.D_rs_val      = s.rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the next-PC rules evaluated directly with integer arithmetic.
  function automatic bit ref_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
  endfunction

  function automatic void ref_next(input stim_t s, input logic [31:0] pc, input logic bd,
                                   output logic [31:0] npc, output logic nbd);
    bit is_branch = (s.bt == 2'd1) || (s.bt == 2'd2);
    bit taken     = (s.bt == 2'd1 && s.eq) || (s.bt == 2'd2 && !s.eq);
    bit is_j      = (s.jt == 2'd1);
    bit is_jr     = (s.jt == 2'd2);
    int off       = int'($signed(s.imm16)) * 4;
    logic [31:0] link = s.dpc + 32'd4;
    if (s.rst)        begin npc = 32'h3000; nbd = 1'b0; end
    else if (s.exc)   begin npc = 32'h4180; nbd = 1'b0; end
    else if (s.stall) begin npc = pc;       nbd = bd;   end
    else if (s.eret)  begin npc = s.epc;    nbd = 1'b0; end
    else begin
      nbd = is_branch || is_j || is_jr;
      if (is_branch && taken)  npc = link + 32'(off);
      else if (is_branch)      npc = pc + 32'd4;
      else if (is_j)           npc = (link & 32'hF000_0000) | (32'(s.imm26) * 4);
      else if (is_jr)          npc = s.rs;
      else                     npc = pc + 32'd4;
    end
  endfunction

  function automatic logic ref_flush(input stim_t s);
    return s.eret && !s.stall && !s.exc;
  endfunction

  function automatic logic [31:0] in_window();
    return 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
  endfunction

  vec_t        vecs[$];
  stim_t       idle;
  stim_t       rst_s;
  stim_t       s;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] n_pc;
  logic        n_bd;

  initial begin
    idle  = mk(0, 0, 0, 0, 32'h0, 2'd0, 0, 2'd0, 32'h3000, 16'h0, 26'h0, 32'h0);
    rst_s = idle; rst_s.rst = 1'b1;

    // Single-cycle vectors, each applied right after reset (F_pc = 0x3000, F_bd = 0).
    //               rst exc stl ert epc            bt  eq jt  dpc            imm16     imm26         rs
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd0, 32'h3000, 16'h0000, 26'h0,       32'h0),          32'h0000_3004, 0, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd1, 1, 2'd0, 32'h3010, 16'hFFFC, 26'h0,       32'h0),          32'h0000_3004, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd1, 1, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_3144, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd1, 0, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_3004, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd2, 0, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_3144, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd2, 1, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_3004, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd1, 32'h3020, 16'h0000, 26'h0000D00, 32'h0),          32'h0000_3400, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd1, 32'hEFFF_FFFC, 16'h0, 26'h0000D00, 32'h0),        32'hF000_3400, 1, 0, 1));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd2, 32'h3020, 16'h0000, 26'h0,       32'h0000_3402),  32'h0000_3402, 1, 0, 1));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd2, 32'h3020, 16'h0000, 26'h0,       32'h0000_6FFC),  32'h0000_6FFC, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd2, 32'h3020, 16'h0000, 26'h0,       32'h0000_7000),  32'h0000_7000, 1, 0, 1));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd2, 32'h3020, 16'h0000, 26'h0,       32'h0000_2FFC),  32'h0000_2FFC, 1, 0, 1));
    vecs.push_back(mv(mk(0, 0, 0, 1, 32'h0000_3100, 2'd0, 0, 2'd0, 32'h3020, 16'h0000, 26'h0,       32'h0),          32'h0000_3100, 0, 1, 0));
    vecs.push_back(mv(mk(0, 0, 1, 1, 32'h0000_3100, 2'd0, 0, 2'd0, 32'h3020, 16'h0000, 26'h0,       32'h0),          32'h0000_3000, 0, 0, 0));
    vecs.push_back(mv(mk(0, 1, 1, 0, 32'h0,         2'd2, 0, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_4180, 0, 0, 0));
    vecs.push_back(mv(mk(0, 1, 0, 1, 32'h0000_3100, 2'd0, 0, 2'd0, 32'h3020, 16'h0000, 26'h0,       32'h0),          32'h0000_4180, 0, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd3, 1, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_3004, 0, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd0, 0, 2'd3, 32'h3100, 16'h0010, 26'h0000D00, 32'h0000_3400),  32'h0000_3004, 0, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd1, 1, 2'd1, 32'h3100, 16'h0010, 26'h0000D00, 32'h0),          32'h0000_3144, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd3, 0, 2'd1, 32'h3020, 16'h0010, 26'h0000D00, 32'h0),          32'h0000_3400, 1, 0, 0));
    vecs.push_back(mv(mk(0, 0, 0, 0, 32'h0,         2'd1, 1, 2'd0, 32'h0000_0000, 16'h8000, 26'h0,  32'h0),          32'hFFFE_0004, 1, 0, 1));
    vecs.push_back(mv(mk(1, 0, 0, 0, 32'h0,         2'd1, 1, 2'd0, 32'h3100, 16'h0010, 26'h0,       32'h0),          32'h0000_3000, 0, 0, 0));

    drive(rst_s);
    step();

    foreach (vecs[i]) begin
      drive(rst_s);
      step();
      drive(vecs[i].s);
      #1;
      check($sformatf("vec%0d flush_F", i), 32'(bus.flush_F), 32'(vecs[i].flush));
      step();
      check($sformatf("vec%0d F_pc", i), bus.F_pc, vecs[i].pc);
      check($sformatf("vec%0d F_bd", i), 32'(bus.F_bd), 32'(vecs[i].bd));
      check($sformatf("vec%0d F_exc_adel", i), 32'(bus.F_exc_adel), 32'(vecs[i].adel));
    end

    // Reset then free-running fetch.
    drive(rst_s);
    step();
    check("reset F_pc", bus.F_pc, 32'h3000);
    check("reset F_bd", 32'(bus.F_bd), 32'd0);
    check("reset F_exc_adel", 32'(bus.F_exc_adel), 32'd0);
    check("reset flush_F", 32'(bus.flush_F), 32'd0);
    drive(idle);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("free run %0d F_pc", k), bus.F_pc, 32'h3000 + 32'(k * 4));
      check($sformatf("free run %0d F_bd", k), 32'(bus.F_bd), 32'd0);
    end

    // j held by a 2-cycle stall, then taken on release.
    drive(rst_s); step();
    s = mk(0, 0, 1, 0, 32'h0, 2'd0, 0, 2'd1, 32'h3020, 16'h0, 26'h0000D00, 32'h0);
    drive(s);
    step(); check("stall1 F_pc", bus.F_pc, 32'h3000);
    step(); check("stall2 F_pc", bus.F_pc, 32'h3000);
    s.stall = 1'b0; drive(s);
    step(); check("stall release F_pc", bus.F_pc, 32'h3400);
    check("stall release F_bd", 32'(bus.F_bd), 32'd1);

    // F_bd holds through a stall.
    drive(idle); step();
    check("bd idle after jump", 32'(bus.F_bd), 32'd0);
    s = mk(0, 0, 0, 0, 32'h0, 2'd1, 0, 2'd0, 32'h3020, 16'h0010, 26'h0, 32'h0);
    drive(s); step();
    check("bd nt branch F_pc", bus.F_pc, 32'h3408);
    check("bd nt branch F_bd", 32'(bus.F_bd), 32'd1);
    s = idle; s.stall = 1'b1; drive(s); step();
    check("bd hold F_bd", 32'(bus.F_bd), 32'd1);
    check("bd hold F_pc", bus.F_pc, 32'h3408);

    // eret waiting on epc forwarding: no flush while stalled.
    drive(rst_s); step();
    s = mk(0, 0, 1, 1, 32'h0000_3100, 2'd0, 0, 2'd0, 32'h3020, 16'h0, 26'h0, 32'h0);
    drive(s); #1;
    check("eret stalled flush_F", 32'(bus.flush_F), 32'd0);
    step(); check("eret stalled F_pc", bus.F_pc, 32'h3000);
    s.stall = 1'b0; drive(s); #1;
    check("eret release flush_F", 32'(bus.flush_F), 32'd1);
    step(); check("eret release F_pc", bus.F_pc, 32'h3100);
    check("eret release F_bd", 32'(bus.F_bd), 32'd0);

    // exc_req + stall + taken bne, then reset.
    s = mk(0, 1, 1, 0, 32'h0, 2'd2, 0, 2'd0, 32'h3100, 16'h0010, 26'h0, 32'h0);
    drive(s); step();
    check("exc F_pc", bus.F_pc, 32'h4180);
    check("exc F_bd", 32'(bus.F_bd), 32'd0);
    drive(rst_s); step();
    check("exc then reset F_pc", bus.F_pc, 32'h3000);

    // F_pc + 4 wraps after a bad jr.
    s = mk(0, 0, 0, 0, 32'h0, 2'd0, 0, 2'd2, 32'h3020, 16'h0, 26'h0, 32'hFFFF_FFFC);
    drive(s); step();
    check("wrap jr F_pc", bus.F_pc, 32'hFFFF_FFFC);
    check("wrap jr F_exc_adel", 32'(bus.F_exc_adel), 32'd1);
    drive(idle); step();
    check("wrap F_pc", bus.F_pc, 32'h0000_0000);
    check("wrap F_exc_adel", 32'(bus.F_exc_adel), 32'd1);

    // Randomized run against the reference model.
    drive(rst_s); step();
    m_pc = 32'h3000; m_bd = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.exc   = ($urandom_range(0, 19) == 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.eret  = ($urandom_range(0, 9) == 0);
      s.epc   = ($urandom_range(0, 7) == 0) ? $urandom() : in_window();
      s.bt    = 2'($urandom_range(0, 3));
      s.eq    = 1'($urandom_range(0, 1));
      s.jt    = 2'($urandom_range(0, 3));
      s.dpc   = ($urandom_range(0, 15) == 0) ? $urandom() : in_window();
      s.imm16 = 16'($urandom());
      s.imm26 = 26'($urandom());
      s.rs    = ($urandom_range(0, 7) == 0) ? $urandom() : in_window();
      drive(s);
      #1;
      check($sformatf("rand%0d flush_F", n), 32'(bus.flush_F), 32'(ref_flush(s)));
      ref_next(s, m_pc, m_bd, n_pc, n_bd);
      m_pc = n_pc; m_bd = n_bd;
      step();
      check($sformatf("rand%0d F_pc", n), bus.F_pc, m_pc);
      check($sformatf("rand%0d F_bd", n), 32'(bus.F_bd), 32'(m_bd));
      check($sformatf("rand%0d F_exc_adel", n), 32'(bus.F_exc_adel), 32'(ref_adel(m_pc)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit for the pipelined MIPS core. It consumes the D-stage `equal` result from the register comparator, plus the D-stage branch/jump decode and forwarded operands. It holds the F-stage PC register and computes the next PC under stall, branch, jump, eret and exception redirect. It also flags F-stage instruction-fetch address errors and tracks the branch-delay-slot bit for the instruction in F.

## Interface
- No parameters. Constants are fixed:
  - reset PC 0x0000_3000
  - handler 0x0000_4180
  - fetch window 0x0000_3000–0x0000_6FFC
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit freeze of PC and F_bd.
- `exc_req` in 1: CP0 exception/interrupt accepted this cycle.
- `epc` in 32: CP0 EPC value, forwarded.
- `D_eret` in 1: eret decoded in D.
- `D_branch_type` in 2: 00 none, 01 beq, 10 bne, 11 reserved (treated as none).
- `equal` in 1: comparator result for the D-stage rs/rt values.
- `D_jump_type` in 2: 00 none, 01 j/jal, 10 jr/jalr, 11 reserved (treated as none).
- `D_pc` in 32: PC of the instruction in D.
- `D_imm16` in 16: branch offset.
- `D_imm26` in 26: jump index.
- `D_rs_val` in 32: forwarded rs value for jr/jalr.
- `F_pc` out 32: current fetch PC (registered).
- `F_bd` out 1: the instruction in F is a delay-slot instruction (registered).
- `F_exc_adel` out 1: fetch address error, ExcCode 4 (combinational from F_pc).
- `flush_F` out 1: kill the instruction in F; applies to the eret slot (combinational).

## Operation
- Next-PC priority, highest first:
  1. `reset` → 0x0000_3000
  2. `exc_req` → 0x0000_4180
  3. `stall` → hold
  4. `D_eret` → `epc`
  5. taken branch → branch target
  6. j/jal → jump target
  7. jr/jalr → `D_rs_val`
  8. otherwise `F_pc + 4`
- Taken branch: beq with `equal`=1, or bne with `equal`=0.
- Branch target: `D_pc + 4 + {{14{D_imm16[15]}}, D_imm16, 2'b00}`, 32-bit wrap-around, no overflow detection.
- Jump target: `{(D_pc+4)[31:28], D_imm26, 2'b00}`.
- Not-taken branch falls through to `F_pc + 4`. The delay slot is always executed, so it is never flushed.
- A branch and a jump never coexist in D. If both are nonzero anyway, branch wins.
- `flush_F` = `D_eret & ~stall & ~exc_req`. eret has no delay slot.
- `F_bd` next value:
  - 0 on `reset`, `exc_req` or unstalled `D_eret`
  - hold on `stall`
  - otherwise `(D_branch_type ∈ {01,10}) | (D_jump_type ∈ {01,10})`
  - `F_bd` is set for any branch, taken or not.
- `F_exc_adel` = `F_pc[1:0]≠0` | `F_pc < 0x3000` | `F_pc > 0x6FFC`.
- Misaligned or out-of-window targets (jr to a bad address, bad epc) are loaded unchanged. The error surfaces through `F_exc_adel` in the following cycle. pc_unit never self-redirects.

## Timing
- Reset values:
  - `F_pc` = 0x0000_3000
  - `F_bd` = 0
  - `F_exc_adel` = 0
  - `flush_F` = 0 while `reset` is held with no eret in D
- Redirect latency: a redirect decided in cycle N (D-stage decode plus `equal` valid in N) appears on `F_pc` in cycle N+1. There are no bubbles beyond the architectural delay slot.
- `stall` freezes both registers for exactly the stalled cycles. The redirect is re-evaluated when the stall releases, using the then-current D inputs.
- `exc_req` wins over a simultaneous `stall`, eret or branch in the same cycle.
- `reset` asserted mid-operation overrides everything on the next edge. No state survives.
- eret waiting on `epc` forwarding is held by `stall`. `flush_F` stays low while stalled.
- The `F_pc + 4` adder wraps at 0xFFFF_FFFC → 0x0000_0000. This is reachable only after an error.

## Test plan
- Reset, then 3 free-running cycles → `F_pc` = 0x3000, 0x3004, 0x3008, 0x300C; `F_bd`=0; `F_exc_adel`=0.
- beq with `D_pc`=0x3010, imm16=0xFFFC, `equal`=1:
  - taken → next `F_pc` = 0x3004, `F_bd`=1
  - same with `equal`=0 → `F_pc` = previous+4, `F_bd`=1
- jr with `D_rs_val`=0x3402 → `F_pc`=0x3402 and `F_exc_adel`=1 the next cycle.
- j with `D_pc`=0x3020, imm26=0x0000D00 → `F_pc`=0x0000_3400. Repeat with `stall` high for 2 cycles → `F_pc` holds, then 0x3400 on release.
- eret with `epc`=0x3100, no stall → `flush_F`=1 in that cycle, next `F_pc`=0x3100, `F_bd`=0.
- `exc_req`, `stall` and a taken bne in the same cycle → `F_pc`=0x4180, `F_bd`=0. `reset` asserted in the next cycle → `F_pc`=0x3000.
